// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer bundle for sync_fifo_flags
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  flush;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_err;

    modport master (
        output flush, write_en, data_in, read_en, clear_err,
        input  data_out, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  flush, write_en, data_in, read_en, clear_err,
        output data_out, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - parametrised single-clock FIFO with status/error flags
// Define FIFO_FWFT_EN for a first-word-fall-through read port; otherwise the read port is registered.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_flags_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0] AF_T    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_T    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W:0]       count_w;
    logic                  empty_w;
    logic                  full_w;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  overflow_q;
    logic                  underflow_q;

    // Flags decode only from registered pointers; the wrap bit separates full from empty.
    assign count_w = wr_ptr - rd_ptr;
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign wr_acc = bus.write_en && !full_w  && !bus.flush;
    assign rd_acc = bus.read_en  && !empty_w && !bus.flush;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !reset) mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
    end

    // A set event in the same cycle as clear_err wins; flush suppresses set events.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (!bus.flush && bus.write_en && full_w) overflow_q <= 1'b1;
            else if (bus.clear_err)                   overflow_q <= 1'b0;
            if (!bus.flush && bus.read_en && empty_w) underflow_q <= 1'b1;
            else if (bus.clear_err)                   underflow_q <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out = mem[rd_ptr[ADDR_W-1:0]];
    assign bus.rd_valid = !empty_w;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;

    // data_out holds its last word when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.flush) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) data_out_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.count        = count_w;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (count_w <= AE_T);
    assign bus.almost_full  = (count_w >= AF_T);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - queue-model and directed-vector bench for sync_fifo_flags
module tb_sync_fifo_flags;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   cmp_en = 0;

    sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO as a queue of words plus sticky flags.
    logic [DW-1:0] q[$];
    logic          m_ovf, m_unf, m_valid;
    logic [DW-1:0] m_data;

    always @(posedge clk) begin
        bit is_full, is_empty, do_rd, do_wr;
        if (reset) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_valid = 0; m_data = '0;
        end else if (bus.flush) begin
            q.delete();
            m_valid = 0;
            if (bus.clear_err) begin m_ovf = 0; m_unf = 0; end
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            if (bus.write_en && is_full) m_ovf = 1;
            else if (bus.clear_err)      m_ovf = 0;
            if (bus.read_en && is_empty) m_unf = 1;
            else if (bus.clear_err)      m_unf = 0;
            do_rd = bus.read_en && !is_empty;
            do_wr = bus.write_en && !is_full;
            m_valid = do_rd;
            if (do_rd) m_data = q.pop_front();
            if (do_wr) q.push_back(bus.data_in);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", bus.count, q.size());
            chk("empty", bus.empty, q.size() == 0);
            chk("full", bus.full, q.size() == DEPTH);
            chk("almost_empty", bus.almost_empty, q.size() <= AE);
            chk("almost_full", bus.almost_full, q.size() >= AF);
            chk("overflow", bus.overflow, m_ovf);
            chk("underflow", bus.underflow, m_unf);
`ifdef FIFO_FWFT_EN
            chk("rd_valid", bus.rd_valid, q.size() != 0);
            if (q.size() != 0) chk("data_out", bus.data_out, q[0]);
`else
            chk("rd_valid", bus.rd_valid, m_valid);
            chk("data_out", bus.data_out, m_data);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        bus.write_en = 1; bus.data_in = d;
        step();
        bus.write_en = 0;
    endtask

    task automatic rd_chk(input logic [DW-1:0] exp);
        bus.read_en = 1;
`ifdef FIFO_FWFT_EN
        chk("lit_rd_data", bus.data_out, exp);
        step();
`else
        step();
        chk("lit_rd_data", bus.data_out, exp);
        chk("lit_rd_valid", bus.rd_valid, 1);
`endif
        bus.read_en = 0;
    endtask

    task automatic clr();
        bus.clear_err = 1;
        step();
        bus.clear_err = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_almost_empty", bus.almost_empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_almost_full", bus.almost_full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_underflow", bus.underflow, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
`ifndef FIFO_FWFT_EN
        chk("rst_data_out", bus.data_out, 0);
`endif
    endtask

    initial begin
        reset = 1;
        bus.flush = 0; bus.write_en = 0; bus.read_en = 0;
        bus.data_in = '0; bus.clear_err = 0;
        step();
        cmp_en = 1;
        step();
        reset = 0;
        chk_reset_vals();

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 16; i++) begin
            wr(DW'(i));
            chk("fill_count", bus.count, i);
            chk("fill_almost_full", bus.almost_full, i >= 14);
        end
        chk("fill_full", bus.full, 1);
        wr(8'h11);
        chk("ovf_count", bus.count, 16);
        chk("ovf_set", bus.overflow, 1);

        // Drain in order, then one rejected read.
        for (int i = 1; i <= 16; i++) begin
            rd_chk(DW'(i));
            chk("drain_almost_empty", bus.almost_empty, (16 - i) <= 2);
        end
        chk("drain_empty", bus.empty, 1);
        bus.read_en = 1; step(); bus.read_en = 0;
        chk("unf_set", bus.underflow, 1);
        clr();
        chk("clr_overflow", bus.overflow, 0);
        chk("clr_underflow", bus.underflow, 0);

        // Wrap-around.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) wr(8'hA0 + DW'(i));
            for (int i = 0; i < 10; i++) rd_chk(8'hA0 + DW'(i));
        end
        chk("wrap_count", bus.count, 0);

        // Simultaneous write+read at count 5.
        for (int i = 0; i < 5; i++) wr(8'h50 + DW'(i));
        for (int k = 0; k < 4; k++) begin
            bus.write_en = 1; bus.read_en = 1; bus.data_in = 8'h55 + DW'(k);
`ifdef FIFO_FWFT_EN
            chk("sim_data", bus.data_out, 8'h50 + DW'(k));
            step();
`else
            step();
            chk("sim_data", bus.data_out, 8'h50 + DW'(k));
`endif
            chk("sim_count", bus.count, 5);
        end
        bus.write_en = 0; bus.read_en = 0;
        for (int i = 0; i < 5; i++) rd_chk(8'h54 + DW'(i));

        // Write+read when full: read accepted, write rejected.
        for (int i = 0; i < 16; i++) wr(8'h60 + DW'(i));
        bus.write_en = 1; bus.read_en = 1; bus.data_in = 8'h99;
        step();
        bus.write_en = 0; bus.read_en = 0;
        chk("full_wr_rd_count", bus.count, 15);
        chk("full_wr_rd_ovf", bus.overflow, 1);
        clr();
        for (int i = 1; i < 16; i++) rd_chk(8'h60 + DW'(i));

        // Write+read when empty: write accepted, read rejected.
        bus.write_en = 1; bus.read_en = 1; bus.data_in = 8'h77;
        step();
        bus.write_en = 0; bus.read_en = 0;
        chk("empty_wr_rd_count", bus.count, 1);
        chk("empty_wr_rd_unf", bus.underflow, 1);
        rd_chk(8'h77);
        clr();

        // Flush at count 7 with overflow set.
        for (int i = 0; i < 16; i++) wr(8'h80 + DW'(i));
        wr(8'hFF);
        for (int i = 0; i < 9; i++) rd_chk(8'h80 + DW'(i));
        chk("pre_flush_count", bus.count, 7);
        bus.flush = 1; bus.write_en = 1; bus.data_in = 8'hEE;
        step();
        bus.flush = 0; bus.write_en = 0;
        chk("flush_count", bus.count, 0);
        chk("flush_empty", bus.empty, 1);
        chk("flush_keeps_ovf", bus.overflow, 1);
        chk("flush_rd_valid", bus.rd_valid, 0);
        wr(8'h42);
        chk("post_flush_count", bus.count, 1);
        rd_chk(8'h42);
        clr();

        // Reset mid-operation at count 9.
        for (int i = 0; i < 9; i++) wr(8'h90 + DW'(i));
        chk("pre_reset_count", bus.count, 9);
        reset = 1;
        step();
        reset = 0;
        chk_reset_vals();
        wr(8'h5A);
        rd_chk(8'h5A);
        step();

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO, the successor to the fixed 16x8 buffer. Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush. The read-port style (first-word-fall-through or registered) is selected at compile time. Sits between any producer/consumer pair in the same clock domain.

## Interface
- DATA_WIDTH, 8, data bus width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- ADDR_W, $clog2(DEPTH), memory index width; derived, not overridden
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- flush  in  1  synchronous clear of contents; keeps error flags
- write_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- read_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- rd_valid  out  1  data_out holds a valid word (see Operation)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_THRESH
- almost_full  out  1  count >= AF_THRESH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clear_err  in  1  clears overflow and underflow

## Operation
- Pointers wr_ptr, rd_ptr are ADDR_W+1 bits; memory index = low ADDR_W bits; MSB is the wrap bit. count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)).
- Write accepted (wr_acc) = write_en && !full. Read accepted (rd_acc) = read_en && !empty. Both evaluated on pre-edge state.
- Simultaneous write+read: when neither full nor empty, both are accepted and count is unchanged. When full, the read is accepted and the write is rejected (overflow set). When empty, the write is accepted and the read is rejected (underflow set).
- Rejected accesses never move pointers or memory.
- overflow sets on write_en && full; underflow sets on read_en && empty. Both hold until clear_err or reset. If a set event and clear_err occur in the same cycle, the set wins.
- Reset: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0, data_out=0. Memory contents are not reset.
- flush: pointers and count go to 0 and rd_valid goes to 0. Error flags are kept. Any write_en/read_en in the same cycle is ignored and does not set the error flags. reset has priority over flush.
- Status flags are decoded from registered pointers; no combinational path from write_en/read_en to any flag.

## Timing
- Write at edge N: count, empty and the almost flags reflect it after edge N.
- Full throughput: one write and one read per cycle, sustained.
- FWFT build: data_out = mem[rd_ptr] combinationally and rd_valid = !empty. A word written at edge N is on data_out in cycle N+1. read_en acknowledges the word already shown.
- Registered build: on rd_acc at edge N, data_out is loaded with mem[rd_ptr] and rd_valid=1 for cycle N+1. rd_valid is 0 after any edge with no rd_acc; data_out then holds its last value.
- Wrap-around: the pointer low bits roll DEPTH-1 -> 0 and the MSB toggles. full = (MSB differ && low bits equal).

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through read port as above. Read latency 0; data_out is undefined-don't-care while empty and is not checked.
- FIFO_FWFT_EN undefined: registered read port. Read latency 1 cycle; data_out is a flop reset to 0.

## Test plan
- Reset then fill: write 0x01..0x10 with DEPTH=16 -> count steps 1..16. almost_full rises when count reaches 14. full=1 after the 16th write. A 17th write keeps count=16 and sets overflow=1.
- Drain: read 16 times -> data 0x01..0x10 in order (latency per build). almost_empty rises at count 2. empty=1 at the end. An extra read sets underflow=1. Then clear_err -> both error flags 0.
- Wrap: repeat 3x (write 10, read 10) with data 0xA0+i -> order preserved across the pointer wrap; count ends at 0.
- Simultaneous: at count 5, assert write_en+read_en for 4 cycles -> count stays 5 and the output order is intact. When full, write+read -> count 15 and overflow=1. When empty, write+read -> count 1 and underflow=1.
- Flush mid-stream: count 7 with overflow=1, then assert flush along with write_en -> count=0, empty=1, overflow still 1, and the write is discarded.
- Reset mid-operation: at count 9, assert reset for 1 cycle -> all outputs at their reset values on the next cycle. The next write/read returns the new data, not stale data.
